// File: rtl/ivs_onehot_enc_pend.sv
// Slot-index to one-hot encoder with a 2-entry skid buffer and a sticky pending-slot mask.
// Optional duplicate-set pulse on dup_err when IVS_ONEHOT_ENC_DUP_ERR_EN is defined.
module ivs_onehot_enc_pend #(
  parameter  int W = 5,
  localparam int N = 2**W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         idx_vld,
  input  logic [W-1:0] idx,
  output logic         idx_rdy,
  output logic         oh_vld,
  output logic [N-1:0] oh,
  input  logic         oh_rdy,
  input  logic [N-1:0] clr,
  output logic [N-1:0] pend,
  output logic         pend_any,
  output logic         dup_err
);

  function automatic logic [N-1:0] onehot_f(input logic [W-1:0] i);
    logic [N-1:0] v;
    v    = {N{1'b0}};
    v[i] = 1'b1;
    return v;
  endfunction

  logic [W-1:0] buf_r [2];
  logic         wr_ptr_r, rd_ptr_r;
  logic [1:0]   cnt_r, cnt_nxt_s;
  logic         rdy_r;
  logic         oh_vld_r;
  logic [N-1:0] oh_r, pend_r, pend_nxt_s, set_vec_s;
  logic         pend_any_r;
  logic         in_xfer_s, has_buf_s, load_s, rd_s, wr_s;
  logic [W-1:0] src_idx_s;

  // Source selection, buffer bookkeeping and pending-mask next state
  always_comb begin
    in_xfer_s = idx_vld & rdy_r;
    has_buf_s = (cnt_r != 2'd0);
    if (has_buf_s) begin
      src_idx_s = buf_r[rd_ptr_r];
    end else begin
      src_idx_s = idx;
    end
    load_s = (~oh_vld_r | oh_rdy) & (has_buf_s | in_xfer_s);
    rd_s   = load_s & has_buf_s;
    // An index that bypasses straight into the output stage never occupies the buffer
    wr_s   = in_xfer_s & ~(load_s & ~has_buf_s);
    if (load_s) begin
      set_vec_s = onehot_f(src_idx_s);
    end else begin
      set_vec_s = {N{1'b0}};
    end
    pend_nxt_s = (pend_r & ~clr) | set_vec_s;
    case ({wr_s, rd_s})
      2'b10:   cnt_nxt_s = cnt_r + 2'd1;
      2'b01:   cnt_nxt_s = cnt_r - 2'd1;
      default: cnt_nxt_s = cnt_r;
    endcase
  end

  // Buffer storage, pointers, count and registered ready
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      buf_r[0] <= {W{1'b0}};
      buf_r[1] <= {W{1'b0}};
      wr_ptr_r <= 1'b0;
      rd_ptr_r <= 1'b0;
      cnt_r    <= 2'd0;
      rdy_r    <= 1'b1;
    end else begin
      if (wr_s) begin
        buf_r[wr_ptr_r] <= idx;
        wr_ptr_r        <= ~wr_ptr_r;
      end
      if (rd_s) begin
        rd_ptr_r <= ~rd_ptr_r;
      end
      cnt_r <= cnt_nxt_s;
      rdy_r <= (cnt_nxt_s != 2'd2);
    end
  end

  // Output stage and sticky pending mask
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      oh_vld_r   <= 1'b0;
      oh_r       <= {N{1'b0}};
      pend_r     <= {N{1'b0}};
      pend_any_r <= 1'b0;
    end else begin
      if (load_s) begin
        oh_r     <= set_vec_s;
        oh_vld_r <= 1'b1;
      end else if (oh_rdy) begin
        oh_vld_r <= 1'b0;
      end
      pend_r     <= pend_nxt_s;
      pend_any_r <= |pend_nxt_s;
    end
  end

`ifdef IVS_ONEHOT_ENC_DUP_ERR_EN
  logic dup_r;

  // Flag a load whose slot bit survives this cycle's clear
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dup_r <= 1'b0;
    end else begin
      dup_r <= load_s & (|(set_vec_s & pend_r & ~clr));
    end
  end

  assign dup_err = dup_r;
`else
  assign dup_err = 1'b0;
`endif

  assign idx_rdy  = rdy_r;
  assign oh_vld   = oh_vld_r;
  assign oh       = oh_r;
  assign pend     = pend_r;
  assign pend_any = pend_any_r;

endmodule

// File: tb/tb_ivs_onehot_enc_pend.sv
// Directed and random bench for ivs_onehot_enc_pend with an ordering scoreboard.
module tb_ivs_onehot_enc_pend;
  localparam int W = 5;
  localparam int N = 32;
`ifdef IVS_ONEHOT_ENC_DUP_ERR_EN
  localparam logic DUP_EN = 1'b1;
`else
  localparam logic DUP_EN = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         idx_vld;
  logic [W-1:0] idx;
  logic         idx_rdy;
  logic         oh_vld;
  logic [N-1:0] oh;
  logic         oh_rdy;
  logic [N-1:0] clr;
  logic [N-1:0] pend;
  logic         pend_any;
  logic         dup_err;

  int errors = 0;
  int checks = 0;
  logic [N-1:0] sb [$];

  ivs_onehot_enc_pend #(.W(W)) dut (
    .clk(clk), .rst(rst), .idx_vld(idx_vld), .idx(idx), .idx_rdy(idx_rdy),
    .oh_vld(oh_vld), .oh(oh), .oh_rdy(oh_rdy), .clr(clr),
    .pend(pend), .pend_any(pend_any), .dup_err(dup_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: push on input transfer, pop and compare on output transfer
  always @(negedge clk) begin
    if (rst === 1'b0) begin
      if (idx_vld && idx_rdy) begin
        logic [N-1:0] e;
        e = {N{1'b0}};
        e[idx] = 1'b1;
        sb.push_back(e);
      end
      if (oh_vld && oh_rdy) begin
        chk("onehot", {{(N-1){1'b0}}, $onehot(oh)}, {{(N-1){1'b0}}, 1'b1});
        if (sb.size() == 0) begin
          chk("sb_underflow", oh, {N{1'b0}});
        end else begin
          chk("sb_order", oh, sb.pop_front());
        end
      end
    end
  end

  initial begin
    int sent;
    int cyc;
    rst = 1'b1; idx_vld = 1'b0; idx = 5'd0; oh_rdy = 1'b0; clr = {N{1'b0}};
    step(); step();
    rst = 1'b0;
    step();
    chk("rst_idx_rdy", {31'd0, idx_rdy}, 32'd1);
    chk("rst_oh_vld", {31'd0, oh_vld}, 32'd0);
    chk("rst_oh", oh, 32'd0);
    chk("rst_pend", pend, 32'd0);
    chk("rst_pend_any", {31'd0, pend_any}, 32'd0);
    chk("rst_dup", {31'd0, dup_err}, 32'd0);

    // back-to-back 0, 5, 31 with downstream ready
    oh_rdy = 1'b1; idx_vld = 1'b1; idx = 5'd0;
    step(); chk("b2b_vld0", {31'd0, oh_vld}, 32'd1); chk("b2b_oh0", oh, 32'h1);
    idx = 5'd5;
    step(); chk("b2b_oh5", oh, 32'h20);
    idx = 5'd31;
    step(); chk("b2b_oh31", oh, 32'h8000_0000);
    idx_vld = 1'b0;
    step(); chk("b2b_drain", {31'd0, oh_vld}, 32'd0);
    chk("b2b_oh_hold", oh, 32'h8000_0000);
    chk("b2b_pend", pend, 32'h8000_0021);
    chk("b2b_pend_any", {31'd0, pend_any}, 32'd1);
    clr = {N{1'b1}};
    step(); clr = {N{1'b0}};
    chk("clr_all", pend, 32'd0);

    // stall: 3 bypasses into oh, 7 and 9 fill the buffer
    oh_rdy = 1'b0; idx_vld = 1'b1; idx = 5'd3;
    step(); chk("stall_oh3", oh, 32'h8); chk("stall_rdy1", {31'd0, idx_rdy}, 32'd1);
    idx = 5'd7;
    step(); chk("stall_rdy2", {31'd0, idx_rdy}, 32'd1);
    idx = 5'd9;
    step(); chk("stall_full", {31'd0, idx_rdy}, 32'd0); chk("stall_hold", oh, 32'h8);
    step(); chk("stall_hold2", oh, 32'h8); chk("stall_vld", {31'd0, oh_vld}, 32'd1);
    idx_vld = 1'b0; oh_rdy = 1'b1;
    step(); chk("drain_oh7", oh, 32'h80); chk("drain_rdy", {31'd0, idx_rdy}, 32'd1);
    step(); chk("drain_oh9", oh, 32'h200);
    step(); chk("drain_empty", {31'd0, oh_vld}, 32'd0);
    chk("drain_pend", pend, 32'h288);
    clr = {N{1'b1}};
    step(); clr = {N{1'b0}};

    // set wins over clear on the same bit
    idx_vld = 1'b1; idx = 5'd4;
    step(); chk("sw_pend_set", pend, 32'h10);
    clr = 32'h10;
    step(); chk("sw_pend_win", pend, 32'h10);
    chk("sw_no_dup", {31'd0, dup_err}, 32'd0);
    idx_vld = 1'b0;
    step(); chk("sw_clr", pend, 32'd0); chk("sw_clr_any", {31'd0, pend_any}, 32'd0);
    clr = {N{1'b0}};

    // duplicate detection: idx 2 twice, then once more under a clear
    idx_vld = 1'b1; idx = 5'd2;
    step(); chk("dup_first", {31'd0, dup_err}, 32'd0);
    step(); chk("dup_second", {31'd0, dup_err}, {31'd0, DUP_EN});
    idx_vld = 1'b0;
    step(); chk("dup_pulse_end", {31'd0, dup_err}, 32'd0);
    idx_vld = 1'b1; clr = 32'h4;
    step(); chk("dup_cleared", {31'd0, dup_err}, 32'd0); chk("dup_pend", pend, 32'h4);
    idx_vld = 1'b0; clr = {N{1'b0}};
    step();

    // reset mid-stream with a full buffer and a valid output
    oh_rdy = 1'b0; idx_vld = 1'b1; idx = 5'd1;
    step(); idx = 5'd2;
    step(); idx = 5'd3;
    step(); chk("mid_full", {31'd0, idx_rdy}, 32'd0); chk("mid_vld", {31'd0, oh_vld}, 32'd1);
    idx_vld = 1'b0; rst = 1'b1;
    #1;
    chk("mid_rst_vld", {31'd0, oh_vld}, 32'd0);
    chk("mid_rst_oh", oh, 32'd0);
    chk("mid_rst_pend", pend, 32'd0);
    sb.delete();
    step(); rst = 1'b0;
    step(); chk("mid_rst_rdy", {31'd0, idx_rdy}, 32'd1);

    // random traffic
    sent = 0;
    for (cyc = 0; cyc < 60000 && sent < 10000; cyc++) begin
      idx_vld = ($urandom_range(0, 3) != 0);
      idx     = 5'($urandom_range(0, N - 1));
      oh_rdy  = ($urandom_range(0, 3) != 0);
      if (idx_vld && idx_rdy) sent++;
      step();
    end
    idx_vld = 1'b0; oh_rdy = 1'b1;
    chk("rand_sent", sent, 32'd10000);
    for (int i = 0; i < 10 && sb.size() != 0; i++) step();
    step();
    chk("rand_sb_empty", sb.size(), 32'd0);
    chk("rand_idle", {31'd0, oh_vld}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
